// File: rtl/biquad_pkg.sv
// Shared constants, coefficient-loader state and width helpers for the
// biquad incremental stage.
package biquad_pkg;

    localparam int COEFF_BITS = 18;
    localparam int ACC_BITS   = 48;

    typedef enum logic [1:0] {
        CS_EMPTY = 2'd0,
        CS_HALF  = 2'd1,
        CS_FULL  = 2'd2
    } coeff_state_e;

    // Right shift that takes a value from in_frac to out_frac fractional bits.
    function automatic int rs_shift(input int in_frac, input int out_frac);
        return (in_frac > out_frac) ? (in_frac - out_frac) : 0;
    endfunction

    // One guard bit so adding the rounding half can never overflow.
    function automatic int rs_ext_w(input int in_w);
        return in_w + 1;
    endfunction

endpackage

// File: rtl/biquad_round_sat.sv
// Round-half-up to OUT_FRAC fractional bits, then saturate to OUT_W signed.
// sat_o flags any clipping.
module biquad_round_sat
    import biquad_pkg::*;
#(
    parameter int IN_W     = 50,
    parameter int IN_FRAC  = 27,
    parameter int OUT_W    = 12,
    parameter int OUT_FRAC = 0
) (
    input  logic [IN_W-1:0]  dat_i,
    output logic [OUT_W-1:0] dat_o,
    output logic             sat_o
);

    localparam int SH = rs_shift(IN_FRAC, OUT_FRAC);
    localparam int EW = rs_ext_w(IN_W);

    localparam logic signed [EW-1:0] HALF = (EW'(1) << SH) >> 1;
    localparam logic signed [EW-1:0] MAXV = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EW-1:0] MINV = {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] rnd;
    logic signed [EW-1:0] shf;

    always_comb begin
        ext   = {{(EW-IN_W){dat_i[IN_W-1]}}, dat_i};
        rnd   = ext + HALF;
        shf   = rnd >>> SH;
        sat_o = 1'b0;
        dat_o = shf[OUT_W-1:0];
        if (shf > MAXV) begin
            dat_o = MAXV[OUT_W-1:0];
            sat_o = 1'b1;
        end else if (shf < MINV) begin
            dat_o = MINV[OUT_W-1:0];
            sat_o = 1'b1;
        end
    end

endmodule

// File: rtl/biquad_incremental_sat.sv
// Incremental biquad stage: y[i] = C0*y[i-2] + C1*y[i-1] + x[i] for i >= 2,
// with double-buffered coefficients and per-sample round/saturate outputs.
module biquad_incremental_sat
    import biquad_pkg::*;
#(
    parameter int NBITS      = 16,
    parameter int NFRAC      = 2,
    parameter int NBITS2     = 30,
    parameter int NFRAC2     = 13,
    parameter int NSAMP      = 8,
    parameter int COEFF_FRAC = 14,
    parameter int OUTBITS    = 12,
    parameter int OUTFRAC    = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NBITS*NSAMP-1:0]   x_in,
    input  logic [NBITS2-1:0]        y0_in,
    input  logic [NBITS2-1:0]        y1_in,
    input  logic                     valid_i,
    input  logic [COEFF_BITS-1:0]    coeff_dat_i,
    input  logic                     coeff_wr_i,
    input  logic                     coeff_update_i,
    output logic                     coeff_busy_o,
    output logic [OUTBITS*NSAMP-1:0] dat_o,
    output logic [NSAMP-1:0]         sat_o,
    output logic                     valid_o
);

    localparam int LAT   = 2 * NSAMP - 2;
    localparam int MID   = LAT - 1;
    localparam int AFRAC = NFRAC2 + COEFF_FRAC;
    localparam int SUM_W = ACC_BITS + 2;
    localparam int XSH   = AFRAC - NFRAC;
    localparam int CW    = $clog2(LAT + 1);

    localparam logic signed [SUM_W-1:0] FB_MAX = {{(SUM_W-NBITS2+1){1'b0}}, {(NBITS2-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] FB_MIN = {{(SUM_W-NBITS2+1){1'b1}}, {(NBITS2-1){1'b0}}};

    function automatic logic signed [NBITS2-1:0] fb_sat(input logic signed [SUM_W-1:0] a);
        logic signed [SUM_W-1:0] t;
        t = a >>> COEFF_FRAC;
        if (t > FB_MAX) t = FB_MAX;
        else if (t < FB_MIN) t = FB_MIN;
        return t[NBITS2-1:0];
    endfunction

    coeff_state_e state_q, state_d, mid_state;
    logic commit, wr_c0, wr_c1;
    logic signed [COEFF_BITS-1:0] sh0_q, sh1_q, act0_q, act1_q;
    logic [CW-1:0] busy_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= CS_EMPTY;
        else     state_q <= state_d;
    end

    // Update is judged on the pre-write state; a same-cycle write lands after it.
    always_comb begin
        commit    = (state_q == CS_FULL) && coeff_update_i && (busy_q == '0);
        mid_state = commit ? CS_EMPTY : state_q;
        state_d   = mid_state;
        if (coeff_wr_i) state_d = (mid_state == CS_HALF) ? CS_FULL : CS_HALF;
    end

    always_comb begin
        wr_c0        = coeff_wr_i && (mid_state != CS_HALF);
        wr_c1        = coeff_wr_i && (mid_state == CS_HALF);
        coeff_busy_o = (busy_q != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh0_q  <= '0;
            sh1_q  <= '0;
            act0_q <= '0;
            act1_q <= '0;
            busy_q <= '0;
        end else begin
            if (wr_c0) sh0_q <= coeff_dat_i;
            if (wr_c1) sh1_q <= coeff_dat_i;
            if (commit) begin
                act0_q <= sh0_q;
                act1_q <= sh1_q;
            end
            if (commit)              busy_q <= CW'(LAT);
            else if (busy_q != '0)   busy_q <= busy_q - CW'(1);
        end
    end

    // Each stage carries its own coefficient pair, so a vector never mixes sets.
    logic                         v_q  [1:MID], v_d  [1:MID];
    logic signed [COEFF_BITS-1:0] k0_q [1:MID], k0_d [1:MID];
    logic signed [COEFF_BITS-1:0] k1_q [1:MID], k1_d [1:MID];
    logic signed [NBITS-1:0]      x_q  [1:MID][NSAMP], x_d  [1:MID][NSAMP];
    logic signed [NBITS2-1:0]     fb_q [1:MID][NSAMP], fb_d [1:MID][NSAMP];
    logic signed [SUM_W-1:0]      y_q  [1:MID][NSAMP], y_d  [1:MID][NSAMP];

    always_comb begin : comb_dp
        logic signed [SUM_W-1:0] p0, p1, xa, acc;
        p0 = '0;
        p1 = '0;
        xa = '0;
        acc = '0;
        v_d[1]  = valid_i;
        k0_d[1] = act0_q;
        k1_d[1] = act1_q;
        for (int i = 0; i < NSAMP; i++) begin
            x_d[1][i]  = x_in[NBITS*i +: NBITS];
            fb_d[1][i] = '0;
            y_d[1][i]  = '0;
        end
        fb_d[1][0] = y0_in;
        fb_d[1][1] = y1_in;
        y_d[1][0]  = {{(SUM_W-NBITS2){y0_in[NBITS2-1]}}, y0_in} <<< COEFF_FRAC;
        y_d[1][1]  = {{(SUM_W-NBITS2){y1_in[NBITS2-1]}}, y1_in} <<< COEFF_FRAC;
        for (int s = 2; s <= MID; s++) begin
            v_d[s]  = v_q[s-1];
            k0_d[s] = k0_q[s-1];
            k1_d[s] = k1_q[s-1];
            x_d[s]  = x_q[s-1];
            fb_d[s] = fb_q[s-1];
            y_d[s]  = y_q[s-1];
            for (int i = 2; i < NSAMP; i++) begin
                if (s == 2 * (i - 1)) begin
                    p0  = k0_q[s-1] * fb_q[s-1][i-2];
                    p1  = k1_q[s-1] * fb_q[s-1][i-1];
                    xa  = {{(SUM_W-NBITS){x_q[s-1][i][NBITS-1]}}, x_q[s-1][i]};
                    xa  = xa <<< XSH;
                    acc = p0 + p1 + xa;
                    y_d[s][i]  = acc;
                    fb_d[s][i] = fb_sat(acc);
                end
            end
        end
    end

    logic [OUTBITS-1:0]       rq [NSAMP];
    logic [NSAMP-1:0]         rs;
    logic [OUTBITS*NSAMP-1:0] dat_q;
    logic [NSAMP-1:0]         sat_q;
    logic                     vo_q;

    for (genvar g = 0; g < NSAMP; g++) begin : g_rs
        biquad_round_sat #(
            .IN_W    (SUM_W),
            .IN_FRAC (AFRAC),
            .OUT_W   (OUTBITS),
            .OUT_FRAC(OUTFRAC)
        ) u_rs (
            .dat_i(y_q[MID][g]),
            .dat_o(rq[g]),
            .sat_o(rs[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 1; s <= MID; s++) begin
                v_q[s]  <= 1'b0;
                k0_q[s] <= '0;
                k1_q[s] <= '0;
                for (int i = 0; i < NSAMP; i++) begin
                    x_q[s][i]  <= '0;
                    fb_q[s][i] <= '0;
                    y_q[s][i]  <= '0;
                end
            end
            dat_q <= '0;
            sat_q <= '0;
            vo_q  <= 1'b0;
        end else begin
            v_q  <= v_d;
            k0_q <= k0_d;
            k1_q <= k1_d;
            x_q  <= x_d;
            fb_q <= fb_d;
            y_q  <= y_d;
            for (int i = 0; i < NSAMP; i++) dat_q[OUTBITS*i +: OUTBITS] <= rq[i];
            sat_q <= rs;
            vo_q  <= v_q[MID];
        end
    end

    assign dat_o   = dat_q;
    assign sat_o   = sat_q;
    assign valid_o = vo_q;

endmodule

// File: tb/tb_biquad_incremental_sat.sv
// Randomised bench for biquad_incremental_sat against an arithmetic reference
// model of the recursion, requantiser and coefficient loader.
module tb_biquad_incremental_sat;

    localparam int NBITS   = 16;
    localparam int NSAMP   = 8;
    localparam int NBITS2  = 30;
    localparam int OUTBITS = 12;
    localparam int LAT     = 2 * NSAMP - 2;
    localparam int DW      = OUTBITS * NSAMP;
    localparam int QW      = 32 + NSAMP + DW;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NBITS*NSAMP-1:0]   x_in;
    logic [NBITS2-1:0]        y0_in, y1_in;
    logic                     valid_i;
    logic [17:0]              coeff_dat_i;
    logic                     coeff_wr_i, coeff_update_i, coeff_busy_o;
    logic [DW-1:0]            dat_o;
    logic [NSAMP-1:0]         sat_o;
    logic                     valid_o;

    biquad_incremental_sat dut (
        .clk(clk), .rst(rst), .x_in(x_in), .y0_in(y0_in), .y1_in(y1_in),
        .valid_i(valid_i), .coeff_dat_i(coeff_dat_i), .coeff_wr_i(coeff_wr_i),
        .coeff_update_i(coeff_update_i), .coeff_busy_o(coeff_busy_o),
        .dat_o(dat_o), .sat_o(sat_o), .valid_o(valid_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    logic [QW-1:0] exp_q[$];

    int     m_state = 0;
    int     m_busy = 0;
    longint m_sh0 = 0, m_sh1 = 0, m_c0 = 0, m_c1 = 0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [NSAMP+DW-1:0] model_vec(input logic [NBITS*NSAMP-1:0] xv,
                                                      input logic [NBITS2-1:0] y0,
                                                      input logic [NBITS2-1:0] y1,
                                                      input longint c0, input longint c1);
        longint fb[NSAMP];
        longint yf, r, xs, t;
        logic [DW-1:0] d;
        logic [NSAMP-1:0] s;
        d = '0;
        s = '0;
        for (int i = 0; i < NSAMP; i++) begin
            if (i == 0) begin
                fb[i] = longint'($signed(y0));
                yf = fb[i] * 16384;
            end else if (i == 1) begin
                fb[i] = longint'($signed(y1));
                yf = fb[i] * 16384;
            end else begin
                xs = longint'($signed(xv[NBITS*i +: NBITS]));
                yf = c0 * fb[i-2] + c1 * fb[i-1] + xs * 33554432;
                t = yf >>> 14;
                if (t > 536870911) t = 536870911;
                if (t < -536870912) t = -536870912;
                fb[i] = t;
            end
            r = (yf + 67108864) >>> 27;
            if (r > 2047) begin r = 2047; s[i] = 1'b1; end
            if (r < -2048) begin r = -2048; s[i] = 1'b1; end
            d[OUTBITS*i +: OUTBITS] = r[OUTBITS-1:0];
        end
        return {s, d};
    endfunction

    function automatic logic [NBITS*NSAMP-1:0] fill_x(input int raw);
        logic [NBITS*NSAMP-1:0] v;
        for (int i = 0; i < NSAMP; i++) v[NBITS*i +: NBITS] = NBITS'(raw);
        return v;
    endfunction

    function automatic logic [NBITS*NSAMP-1:0] rand_x();
        logic [NBITS*NSAMP-1:0] v;
        for (int i = 0; i < NSAMP; i++)
            v[NBITS*i +: NBITS] = ($urandom_range(0, 3) == 0) ? NBITS'($urandom)
                                  : NBITS'(int'($urandom_range(0, 2000)) - 1000);
        return v;
    endfunction

    function automatic logic [NBITS2-1:0] rand_y();
        return ($urandom_range(0, 3) == 0) ? NBITS2'($urandom)
               : NBITS2'(int'($urandom_range(0, 65535)) - 32768);
    endfunction

    task automatic step(input bit v, input logic [NBITS*NSAMP-1:0] xv,
                        input logic [NBITS2-1:0] y0, input logic [NBITS2-1:0] y1,
                        input bit wr, input logic [17:0] cd, input bit upd);
        bit commit;
        int st;
        valid_i = v; x_in = xv; y0_in = y0; y1_in = y1;
        coeff_wr_i = wr; coeff_dat_i = cd; coeff_update_i = upd;
        @(posedge clk);
        cyc++;
        commit = (m_state == 2) && upd && (m_busy == 0);
        if (v) exp_q.push_back({32'(cyc + LAT - 1), model_vec(xv, y0, y1, m_c0, m_c1)});
        if (commit) begin
            m_c0 = m_sh0;
            m_c1 = m_sh1;
            m_busy = LAT;
        end else if (m_busy > 0) begin
            m_busy--;
        end
        st = commit ? 0 : m_state;
        if (wr) begin
            if (st == 1) begin m_sh1 = longint'($signed(cd)); st = 2; end
            else begin m_sh0 = longint'($signed(cd)); st = 1; end
        end
        m_state = st;
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1; valid_i = 1'b0; coeff_wr_i = 1'b0; coeff_update_i = 1'b0;
        @(posedge clk);
        cyc++;
        exp_q.delete();
        m_state = 0; m_busy = 0; m_sh0 = 0; m_sh1 = 0; m_c0 = 0; m_c1 = 0;
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin : mon
        logic [QW-1:0] e;
        bit due_now;
        if (mon_en) begin
            due_now = 1'b0;
            if (exp_q.size() > 0) begin
                e = exp_q[0];
                due_now = (int'(e[QW-1 -: 32]) == cyc);
            end
            check("valid_o", valid_o, due_now);
            check("coeff_busy_o", coeff_busy_o, m_busy != 0);
            if (due_now) begin
                e = exp_q.pop_front();
                if (valid_o) begin
                    check("dat_o", dat_o, e[DW-1:0]);
                    check("sat_o", sat_o, e[DW +: NSAMP]);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; valid_i = 1'b0; x_in = '0; y0_in = '0; y1_in = '0;
        coeff_dat_i = '0; coeff_wr_i = 1'b0; coeff_update_i = 1'b0;
        do_reset();
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_dat", dat_o, 0);
        check("rst_sat", sat_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_busy", coeff_busy_o, 0);

        // pass-through with zero coefficients
        step(1'b1, fill_x(16), '0, '0, 1'b0, '0, 1'b0);
        for (int k = 0; k < 6; k++) step(1'b1, rand_x(), rand_y(), rand_y(), 1'b0, '0, 1'b0);
        idle(LAT);

        // accumulator: C0 = 0, C1 = 1.0
        step(1'b0, '0, '0, '0, 1'b1, 18'd0, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1, 18'd16384, 1'b0);
        step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
        step(1'b1, fill_x(16), '0, '0, 1'b0, '0, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b1, rand_x(), rand_y(), rand_y(), 1'b0, '0, 1'b0);
        idle(LAT);

        // saturation both directions
        step(1'b1, fill_x(4000), '0, '0, 1'b0, '0, 1'b0);
        step(1'b1, fill_x(-4000), '0, '0, 1'b0, '0, 1'b0);
        idle(LAT);

        // loader edge cases
        do_reset();
        step(1'b0, '0, '0, '0, 1'b1, 18'd5000, 1'b0);
        step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
        step(1'b1, fill_x(16), '0, '0, 1'b0, '0, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1, 18'd8000, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1, 18'(-2000), 1'b0);
        step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
        step(1'b1, fill_x(40), 30'd8192, 30'd16384, 1'b0, '0, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1, 18'd16384, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1, 18'd0, 1'b0);
        step(1'b1, fill_x(40), 30'd8192, 30'd16384, 1'b0, '0, 1'b1);
        idle(LAT);
        step(1'b1, fill_x(40), 30'd8192, 30'd16384, 1'b0, '0, 1'b1);
        step(1'b1, fill_x(40), 30'd8192, 30'd16384, 1'b0, '0, 1'b0);
        idle(LAT);

        // continuous stream with commits mid-stream, including write+update together
        step(1'b1, fill_x(16), '0, '0, 1'b1, 18'd0, 1'b0);
        step(1'b1, fill_x(16), '0, '0, 1'b1, 18'd16384, 1'b0);
        for (int k = 0; k < LAT + 3; k++) step(1'b1, fill_x(16), '0, '0, 1'b0, '0, k == 0);
        step(1'b1, fill_x(16), '0, '0, 1'b1, 18'd0, 1'b0);
        step(1'b1, fill_x(16), '0, '0, 1'b1, 18'd0, 1'b0);
        step(1'b1, fill_x(16), '0, '0, 1'b1, 18'd7000, 1'b1);
        for (int k = 0; k < 6; k++) step(1'b1, fill_x(16), '0, '0, 1'b0, '0, 1'b0);
        idle(LAT);

        // randomised traffic
        for (int k = 0; k < 400; k++)
            step($urandom_range(0, 3) != 0, rand_x(), rand_y(), rand_y(),
                 $urandom_range(0, 3) == 0, 18'($urandom), $urandom_range(0, 7) == 0);

        // reset with vectors in flight, then pass-through
        for (int k = 0; k < 5; k++) step(1'b1, rand_x(), rand_y(), rand_y(), 1'b0, '0, 1'b0);
        do_reset();
        for (int k = 0; k < 3; k++) step(1'b1, rand_x(), rand_y(), rand_y(), 1'b0, '0, 1'b1);

        idle(LAT + 4);
        check("drain_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
